// File: rtl/div_16b_seq.sv
// Multi-cycle 16-bit restoring divider (start/done handshake) built on a 16-bit CLA.
// Optional macro DIV_SIGNED_EN selects two's-complement operands (truncating division).

module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // First level: 4-bit groups with full in-group lookahead
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign gp[gi] = &p[B+3:B];
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);
    end
  endgenerate

  // Second level: group carries straight from cin
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  assign c[16] = gc[4];

  assign sum  = p ^ c[15:0];
  assign cout = c[16];
endmodule

module div_16b_seq #(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     q_reg, q_next;
  logic [N:0]       r_reg, r_next;
  logic [N-1:0]     dvsr_reg, dvsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N-1:0]     quot_reg, quot_next;
  logic [N-1:0]     rem_reg, rem_next;
  logic             dz_reg, dz_next;

  logic [N:0]       r_shift;
  logic [N-1:0]     diff_lo;
  logic             carry_lo;
  logic             no_borrow;
  logic [N:0]       r_iter;
  logic [N-1:0]     q_iter;
  logic [N-1:0]     quot_fin;
  logic [N-1:0]     rem_fin;
  logic [N-1:0]     dz_rem_fin;
  logic [N-1:0]     dvd_lat;
  logic [N-1:0]     dvsr_lat;

  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};

  cla_16 u_cla (
    .a    (r_shift[N-1:0]),
    .b    (~dvsr_reg),
    .cin  (1'b1),
    .sum  (diff_lo),
    .cout (carry_lo)
  );

  // Top bit of R - {0,D}: the extra divisor bit is 0, so its inverse is 1
  assign no_borrow = r_shift[N] | carry_lo;
  assign r_iter    = no_borrow ? {~(r_shift[N] ^ carry_lo), diff_lo} : r_shift;
  assign q_iter    = {q_reg[N-2:0], no_borrow};

`ifdef DIV_SIGNED_EN
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;

  assign dvd_lat    = dividend[N-1] ? (~dividend + N'(1)) : dividend;
  assign dvsr_lat   = divisor[N-1]  ? (~divisor + N'(1))  : divisor;
  assign quot_fin   = neg_q_reg ? (~q_iter + N'(1)) : q_iter;
  assign rem_fin    = neg_r_reg ? (~r_iter[N-1:0] + N'(1)) : r_iter[N-1:0];
  // q_reg still holds |dividend|; restoring its sign yields the original dividend
  assign dz_rem_fin = neg_r_reg ? (~q_reg + N'(1)) : q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
    end
  end

  always_comb begin
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    if (state_reg == IDLE && start) begin
      neg_q_next = dividend[N-1] ^ divisor[N-1];
      neg_r_next = dividend[N-1];
    end
  end
`else
  assign dvd_lat    = dividend;
  assign dvsr_lat   = divisor;
  assign quot_fin   = q_iter;
  assign rem_fin    = r_iter[N-1:0];
  assign dz_rem_fin = q_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      dvsr_reg  <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dvsr_reg  <= dvsr_next;
      cnt_reg   <= cnt_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dz_reg    <= dz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dvsr_next  = dvsr_reg;
    cnt_next   = cnt_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          q_next     = dvd_lat;
          r_next     = '0;
          dvsr_next  = dvsr_lat;
          cnt_next   = '0;
          dz_next    = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Zero divisor is detected on the latched value and finishes on the first RUN edge
        if (dvsr_reg == '0) begin
          quot_next  = '1;
          rem_next   = dz_rem_fin;
          dz_next    = 1'b1;
          state_next = DONE;
        end else begin
          q_next   = q_iter;
          r_next   = r_iter;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N - 1)) begin
            quot_next  = quot_fin;
            rem_next   = rem_fin;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dz_reg;
endmodule
